// File: rtl/rv_csr_file.sv
// CSR file for the execute stage: decodes CSR ops, owns counters and scratch registers, forwards trap-CSR writes.
// Latency: one cycle from accept to x_valid_o / x_rd_o; scratch writes commit on the accept edge.
// Backpressure: x_stall_i holds every registered output; x_kill_i suppresses the op entirely.
module rv_csr_file #(
  parameter int CNT_WIDTH = 40,
  parameter int N_SCRATCH = 4,
  parameter int TIME_DIV  = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic        d_is_csr_i,
  input  logic [2:0]  d_fun_i,
  input  logic [4:0]  d_csr_imm_i,
  input  logic [11:0] d_csr_sel_i,
  input  logic [31:0] d_rs1_i,
  input  logic        w_retire_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic [31:0] csr_mip_i,
  input  logic [31:0] csr_mie_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mcause_i,
  output logic [31:0] x_rd_o,
  output logic        x_valid_o,
  output logic        x_illegal_o,
  output logic        x_csr_we_o,
  output logic [11:0] x_csr_sel_o,
  output logic [31:0] x_csr_write_value_o
);

  localparam logic [7:0]           PRESC_MAX = 8'(TIME_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cycle;
  logic [CNT_WIDTH-1:0] r_time;
  logic [CNT_WIDTH-1:0] r_instret;
  logic [7:0]           r_presc;
  logic [31:0]          r_scratch [N_SCRATCH];

  logic [31:0] r_rd;
  logic        r_valid;
  logic        r_illegal;
  logic        r_we;
  logic [11:0] r_sel;
  logic [31:0] r_wval;

  logic        w_accept;
  logic [31:0] w_src;
  logic        w_wr_intent;
  logic [31:0] w_old;
  logic [31:0] w_new;
  logic        w_is_cnt;
  logic        w_is_ext;
  logic        w_is_scr;
  logic [2:0]  w_scr_idx;
  logic        w_illegal;
  logic        w_scr_wr;
  logic        w_ext_wr;
  logic [63:0] w_cycle64;
  logic [63:0] w_time64;
  logic [63:0] w_instret64;

  assign w_accept    = d_is_csr_i & ~x_stall_i & ~x_kill_i;
  // Immediate forms (funct3[2] set) use the zero-extended zimm field as operand.
  assign w_src       = d_fun_i[2] ? {27'b0, d_csr_imm_i} : d_rs1_i;
  // Zero-extend counters to 64 bits so the high halves are uniform for any width.
  assign w_cycle64   = 64'(r_cycle);
  assign w_time64    = 64'(r_time);
  assign w_instret64 = 64'(r_instret);

  // Address decode and old-value mux.
  always_comb begin
    w_old     = '0;
    w_is_cnt  = 1'b0;
    w_is_ext  = 1'b0;
    w_is_scr  = 1'b0;
    w_scr_idx = '0;
    case (d_csr_sel_i)
      12'hC00: begin w_is_cnt = 1'b1; w_old = w_cycle64[31:0];    end
      12'hC01: begin w_is_cnt = 1'b1; w_old = w_time64[31:0];     end
      12'hC02: begin w_is_cnt = 1'b1; w_old = w_instret64[31:0];  end
      12'hC80: begin w_is_cnt = 1'b1; w_old = w_cycle64[63:32];   end
      12'hC81: begin w_is_cnt = 1'b1; w_old = w_time64[63:32];    end
      12'hC82: begin w_is_cnt = 1'b1; w_old = w_instret64[63:32]; end
      12'h300: begin w_is_ext = 1'b1; w_old = csr_mstatus_i;      end
      12'h304: begin w_is_ext = 1'b1; w_old = csr_mie_i;          end
      12'h341: begin w_is_ext = 1'b1; w_old = csr_mepc_i;         end
      12'h342: begin w_is_ext = 1'b1; w_old = csr_mcause_i;       end
      12'h344: begin w_is_ext = 1'b1; w_old = csr_mip_i;          end
      12'h340: begin w_is_scr = 1'b1; w_scr_idx = 3'd0;           end
      default: begin
        // 7C1..7C7 map to scratch[1..7]; only indices below N_SCRATCH exist.
        if (d_csr_sel_i[11:3] == 9'h0F8 && d_csr_sel_i[2:0] != 3'd0 &&
            int'({29'b0, d_csr_sel_i[2:0]}) < N_SCRATCH) begin
          w_is_scr  = 1'b1;
          w_scr_idx = d_csr_sel_i[2:0];
        end
      end
    endcase
    if (w_is_scr) begin
      for (int k = 0; k < N_SCRATCH; k++) begin
        if (w_scr_idx == 3'(k)) w_old = r_scratch[k];
      end
    end
  end

  // Read-modify-write value and whether the op intends to write at all.
  always_comb begin
    w_wr_intent = 1'b0;
    w_new       = w_old;
    case (d_fun_i[1:0])
      2'b01: begin w_wr_intent = 1'b1;         w_new = w_src;          end
      2'b10: begin w_wr_intent = |d_csr_imm_i; w_new = w_old | w_src;  end
      2'b11: begin w_wr_intent = |d_csr_imm_i; w_new = w_old & ~w_src; end
      default: ;
    endcase
  end

  assign w_illegal = ~(w_is_cnt | w_is_ext | w_is_scr) | (w_is_cnt & w_wr_intent);
  assign w_scr_wr  = w_accept & w_is_scr & w_wr_intent;
  assign w_ext_wr  = w_accept & w_is_ext & w_wr_intent;

  // Free-running counters and time prescaler; never stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cycle   <= '0;
      r_time    <= '0;
      r_instret <= '0;
      r_presc   <= '0;
    end else begin
      r_cycle <= r_cycle + CNT_ONE;
      if (w_retire_i) r_instret <= r_instret + CNT_ONE;
      if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_time  <= r_time + CNT_ONE;
      end else begin
        r_presc <= r_presc + 8'd1;
      end
    end
  end

  // Scratch bank write port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < N_SCRATCH; k++) r_scratch[k] <= '0;
    end else if (w_scr_wr) begin
      for (int k = 0; k < N_SCRATCH; k++) begin
        if (w_scr_idx == 3'(k)) r_scratch[k] <= w_new;
      end
    end
  end

  // Registered result and external write strobe; hold everything while stalled.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd      <= '0;
      r_valid   <= 1'b0;
      r_illegal <= 1'b0;
      r_we      <= 1'b0;
      r_sel     <= '0;
      r_wval    <= '0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_illegal <= w_illegal;
      r_rd      <= w_illegal ? 32'd0 : w_old;
      r_we      <= w_ext_wr;
      if (w_ext_wr) begin
        r_sel  <= d_csr_sel_i;
        r_wval <= w_new;
      end
    end else if (!x_stall_i) begin
      r_valid <= 1'b0;
      r_we    <= 1'b0;
    end
  end

  assign x_rd_o              = r_rd;
  assign x_valid_o           = r_valid;
  assign x_illegal_o         = r_illegal;
  assign x_csr_we_o          = r_we;
  assign x_csr_sel_o         = r_sel;
  assign x_csr_write_value_o = r_wval;

endmodule

// File: tb/tb_rv_csr_file.sv
// Self-checking bench for rv_csr_file: directed scenarios followed by random CSR traffic
// compared against an arithmetic model of counters, scratch bank and external CSRs.
module tb_rv_csr_file;

  localparam int CW = 40;
  localparam int NS = 4;
  localparam int TD = 4;
  localparam longint unsigned MASK = (64'd1 << CW) - 64'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_stall, x_kill, d_is_csr, w_retire;
  logic [2:0]  d_fun;
  logic [4:0]  d_imm;
  logic [11:0] d_sel;
  logic [31:0] d_rs1;
  logic [31:0] v_mstatus, v_mip, v_mie, v_mepc, v_mcause;
  logic [31:0] x_rd_o;
  logic        x_valid_o, x_illegal_o, x_csr_we_o;
  logic [11:0] x_csr_sel_o;
  logic [31:0] x_csr_write_value_o;

  rv_csr_file #(.CNT_WIDTH(CW), .N_SCRATCH(NS), .TIME_DIV(TD)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .x_stall_i(x_stall), .x_kill_i(x_kill),
    .d_is_csr_i(d_is_csr), .d_fun_i(d_fun), .d_csr_imm_i(d_imm), .d_csr_sel_i(d_sel),
    .d_rs1_i(d_rs1), .w_retire_i(w_retire),
    .csr_mstatus_i(v_mstatus), .csr_mip_i(v_mip), .csr_mie_i(v_mie),
    .csr_mepc_i(v_mepc), .csr_mcause_i(v_mcause),
    .x_rd_o(x_rd_o), .x_valid_o(x_valid_o), .x_illegal_o(x_illegal_o),
    .x_csr_we_o(x_csr_we_o), .x_csr_sel_o(x_csr_sel_o),
    .x_csr_write_value_o(x_csr_write_value_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  longint unsigned m_cycle, m_instret;
  logic [31:0] m_scr [8];
  logic [31:0] e_rd, e_wval;
  logic        e_valid, e_ill, e_we;
  logic [11:0] e_sel;

  logic [11:0] addrs [18] = '{12'hC00, 12'hC01, 12'hC02, 12'hC80, 12'hC81, 12'hC82,
                              12'h300, 12'h304, 12'h341, 12'h342, 12'h344, 12'h340,
                              12'h7C1, 12'h7C2, 12'h7C3, 12'h7C4, 12'h7C7, 12'h123};
  logic [2:0]  funs [6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd7};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic check_all();
    chk("valid",   {31'b0, x_valid_o},   {31'b0, e_valid});
    chk("illegal", {31'b0, x_illegal_o}, {31'b0, e_ill});
    chk("rd",      x_rd_o,               e_rd);
    chk("we",      {31'b0, x_csr_we_o},  {31'b0, e_we});
    chk("sel",     {20'b0, x_csr_sel_o}, {20'b0, e_sel});
    chk("wval",    x_csr_write_value_o,  e_wval);
  endtask

  task automatic model_reset();
    m_cycle = 0; m_instret = 0;
    for (int k = 0; k < 8; k++) m_scr[k] = '0;
    e_rd = '0; e_wval = '0; e_valid = 1'b0; e_ill = 1'b0; e_we = 1'b0; e_sel = '0;
  endtask

  // What a CSR address means, from the address map.
  function automatic void ref_decode(input logic [11:0] a, output bit ok, output bit ro,
                                     output bit ext, output int sidx, output logic [31:0] val);
    longint unsigned t;
    t = (m_cycle / TD) & MASK;
    ok = 1; ro = 0; ext = 0; sidx = -1; val = '0;
    case (a)
      12'hC00: begin ro = 1; val = 32'(m_cycle);         end
      12'hC01: begin ro = 1; val = 32'(t);               end
      12'hC02: begin ro = 1; val = 32'(m_instret);       end
      12'hC80: begin ro = 1; val = 32'(m_cycle >> 32);   end
      12'hC81: begin ro = 1; val = 32'(t >> 32);         end
      12'hC82: begin ro = 1; val = 32'(m_instret >> 32); end
      12'h300: begin ext = 1; val = v_mstatus; end
      12'h304: begin ext = 1; val = v_mie;     end
      12'h341: begin ext = 1; val = v_mepc;    end
      12'h342: begin ext = 1; val = v_mcause;  end
      12'h344: begin ext = 1; val = v_mip;     end
      12'h340: begin sidx = 0; val = m_scr[0]; end
      default: begin
        if (a > 12'h7C0 && a < 12'h7C0 + 12'(NS)) begin
          sidx = int'(a - 12'h7C0);
          val  = m_scr[sidx];
        end else begin
          ok = 0;
        end
      end
    endcase
  endfunction

  // One clock: predict, advance the clock, update the model, compare.
  task automatic step();
    bit acc, ok, ro, ext, wi, legal;
    int sidx;
    logic [31:0] old, src, nv;
    acc = d_is_csr && !x_stall && !x_kill;
    legal = 0; wi = 0; sidx = -1; nv = '0;
    if (acc) begin
      ref_decode(d_sel, ok, ro, ext, sidx, old);
      src = (d_fun >= 3'd5) ? {27'b0, d_imm} : d_rs1;
      case (d_fun)
        3'd1, 3'd5: begin nv = src;        wi = 1;              end
        3'd2, 3'd6: begin nv = old | src;  wi = (d_imm != 0);   end
        3'd3, 3'd7: begin nv = old & ~src; wi = (d_imm != 0);   end
        default:    begin nv = old;        wi = 0;              end
      endcase
      legal   = ok && !(ro && wi);
      e_valid = 1'b1;
      e_ill   = !legal;
      e_rd    = legal ? old : 32'd0;
      e_we    = legal && ext && wi;
      if (e_we) begin e_sel = d_sel; e_wval = nv; end
    end else if (!x_stall) begin
      e_valid = 1'b0;
      e_we    = 1'b0;
    end
    @(posedge clk);
    m_cycle = (m_cycle + 1) & MASK;
    if (w_retire) m_instret = (m_instret + 1) & MASK;
    if (acc && legal && wi && sidx >= 0) m_scr[sidx] = nv;
    #1;
    check_all();
  endtask

  task automatic drive(input logic [2:0] f, input logic [4:0] imm,
                       input logic [11:0] a, input logic [31:0] rs1);
    d_is_csr = 1'b1; d_fun = f; d_imm = imm; d_sel = a; d_rs1 = rs1;
  endtask

  task automatic idle();
    d_is_csr = 1'b0; d_fun = '0; d_imm = '0; d_sel = '0; d_rs1 = '0;
  endtask

  initial begin
    rst_n = 1'b0; x_stall = 0; x_kill = 0; w_retire = 0;
    v_mstatus = 32'h0000_1888; v_mip = 32'h0000_0080; v_mie = 32'h0000_0008;
    v_mepc = 32'h0000_2000; v_mcause = 32'h8000_0007;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();                       // reset state
    rst_n = 1'b1;

    // 10 idle clocks then read cycle
    repeat (10) step();
    drive(3'd2, 5'd0, 12'hC00, 32'h0); step();
    chk("cycle_after_10", x_rd_o, 32'd10);
    chk("cycle_legal", {31'b0, x_illegal_o}, 32'd0);
    idle(); step();
    drive(3'd2, 5'd0, 12'hC01, 32'h0); step();
    chk("time_at_12", x_rd_o, 32'd3);

    // back-to-back scratch RMW
    drive(3'd1, 5'd1, 12'h340, 32'hDEADBEEF); step();
    drive(3'd7, 5'hF, 12'h340, 32'h0);        step();
    chk("rci_old", x_rd_o, 32'hDEADBEEF);
    drive(3'd2, 5'd0, 12'h340, 32'h0);        step();
    chk("rci_new", x_rd_o, 32'hDEADBEE0);

    // writing a read-only counter is illegal; read-only access is legal
    drive(3'd1, 5'd3, 12'hC00, 32'h1234); step();
    chk("ro_write_ill", {31'b0, x_illegal_o}, 32'd1);
    chk("ro_write_rd", x_rd_o, 32'd0);
    drive(3'd2, 5'd0, 12'hC00, 32'hFFFF); step();
    chk("ro_read_legal", {31'b0, x_illegal_o}, 32'd0);

    // stalled external write then release: single strobe
    idle(); step();
    drive(3'd1, 5'd2, 12'h304, 32'h888);
    x_stall = 1; step(); step();
    x_stall = 0; step();
    chk("ext_we", {31'b0, x_csr_we_o}, 32'd1);
    chk("ext_sel", {20'b0, x_csr_sel_o}, 32'h304);
    chk("ext_val", x_csr_write_value_o, 32'h888);
    idle(); step();
    chk("ext_we_drop", {31'b0, x_csr_we_o}, 32'd0);
    drive(3'd1, 5'd2, 12'h304, 32'h888);
    x_kill = 1; step();
    x_kill = 0;
    chk("kill_no_we", {31'b0, x_csr_we_o}, 32'd0);
    chk("kill_no_valid", {31'b0, x_valid_o}, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        v_mstatus = $urandom; v_mip = $urandom; v_mie = $urandom;
        v_mepc = $urandom; v_mcause = $urandom;
      end
      if ($urandom_range(0, 3) != 0)
        drive(funs[$urandom_range(0, 5)],
              ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
              addrs[$urandom_range(0, 17)], $urandom);
      else
        idle();
      x_stall  = ($urandom_range(0, 4) == 0);
      x_kill   = !x_stall && ($urandom_range(0, 9) == 0);
      w_retire = $urandom_range(0, 1) == 1;
      step();
    end
    x_stall = 0; x_kill = 0; w_retire = 0;

    // asynchronous reset mid-operation
    drive(3'd1, 5'd1, 12'h300, 32'hCAFE_F00D); step();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_valid", {31'b0, x_valid_o}, 32'd0);
    chk("arst_we", {31'b0, x_csr_we_o}, 32'd0);
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) step();
    drive(3'd2, 5'd0, 12'hC00, 32'h0); step();
    chk("cycle_after_rst", x_rd_o, 32'd5);
    drive(3'd2, 5'd0, 12'h340, 32'h0); step();
    chk("scratch_after_rst", x_rd_o, 32'd0);
    idle(); step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
